branch_cmp_unit: RTL and testbench
==================================

# branch_cmp_unit

Parametrised, multi-cycle branch comparator for the execute stage: compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, with optional early exit on the first differing chunk. It decodes the RISC-V branch funct3 to produce a taken decision and lt/eq/gt flags. A valid/ready handshake sits on both sides, so the unit can stall the pipeline while it works. It trades latency for area against a full-width single-cycle subtractor.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle. WIDTH % CHUNK == 0; N = WIDTH/CHUNK.
- EARLY_EXIT, 1: 1 = finish on the first unequal chunk; 0 = always examine all N chunks.

- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  reset; synchronous, active-high.
- i_flush  input  1  synchronous abort of any in-flight compare.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept; high only in IDLE.
- i_op_a  input  WIDTH  operand A.
- i_op_b  input  WIDTH  operand B.
- i_funct3  input  3  branch code: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- o_valid  output  1  result valid; held until accepted.
- i_ready  input  1  downstream accepts result.
- o_taken  output  1  branch condition true.
- o_lt, o_eq, o_gt  output  1 each  A relative to B; one-hot when o_valid and not illegal.
- o_illegal  output  1  funct3 was 010 or 011.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - o_ready=1.
  - On i_valid: latch operands, funct3 and the signed flag (funct3[2:1]==2'b10), set chunk index k=N-1, go to BUSY.
  - An illegal funct3 goes directly to DONE with o_illegal=1 and o_taken/lt/eq/gt=0.
- **BUSY**, each cycle, compare chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK):
  - Signed mode, k=N-1 only: invert the top bit of both chunks before the unsigned compare. All other chunks are unsigned.
  - Chunks unequal and no decision recorded yet: record lt or gt. With EARLY_EXIT=1, go to DONE.
  - k==0: go to DONE. If no difference was recorded, the result is eq.
  - Otherwise decrement k.
  - With EARLY_EXIT=0, only the first difference (the most significant one) is recorded.
- **DONE**
  - o_valid=1. Result outputs are registered and stable.
  - On i_ready: go to IDLE.
- o_taken by funct3:
  - BEQ: eq. BNE: !eq.
  - BLT/BLTU: lt.
  - BGE/BGEU: gt|eq.
- Priority, highest first: i_rst, then i_flush, then handshakes.
  - i_flush in any state: IDLE next cycle, o_valid=0, result discarded.
  - i_flush coincident with an accept: the request is dropped.
  - i_flush coincident with an i_ready handshake: the handshake completes and the next state is IDLE either way.
- Reset mid-operation: identical to flush; all state cleared.

## Timing
- Reset values:
  - state=IDLE; o_valid, o_taken, o_lt, o_eq, o_gt, o_illegal = 0.
  - o_ready=0 while i_rst is high, 1 from the first cycle after.
- Accept at cycle T. Chunk m (m=0 is the MSB chunk) is examined at T+1+m.
- Result latency:
  - o_valid rises at T+2+m_decide, where m_decide is the chunk that ended BUSY.
  - Range: T+2 minimum, T+N+1 maximum (equal operands, or EARLY_EXIT=0).
  - Illegal funct3: o_valid at T+1.
- No back-to-back issue: after the output handshake at cycle U, o_ready=1 at U+1 and the earliest next accept is at U+1.
- o_ready is combinational from state only, never from i_valid. o_valid is a registered state decode.
- CHUNK==WIDTH: fixed latency 2.

## Structure
- Shared package branch_pkg:
  - funct3 localparams BR_BEQ..BR_BGEU.
  - state enum for IDLE/BUSY/DONE.
  - A function returning taken from (funct3, lt, eq).
- Sub-module chunk_cmp: combinational CHUNK-bit compare.
  - Inputs: a, b, signed flag.
  - Outputs: lt, eq.
  - One instance, muxed by k.
- Top-level holds the FSM, chunk counter, operand and result registers.

## Test plan
- WIDTH=32, CHUNK=8, BLT, A=0xFFFFFFFF, B=0x00000001 -> o_lt=1, o_taken=1, o_valid at T+2.
- Same operands, BLTU -> o_gt=1, o_taken=0, o_valid at T+2.
- BEQ, A=B=0x12345678 -> o_eq=1, o_taken=1, o_valid at T+5.
  - Same with EARLY_EXIT=0 and BGE, A=0x80000000, B=0 -> o_lt=1, o_taken=0, o_valid at T+5.
- BGE, A=0x00000100, B=0x000000FF -> difference at m=2, o_gt=1, o_taken=1, o_valid at T+4.
- Backpressure: hold i_ready=0 for 3 cycles after o_valid -> outputs stable and o_ready=0. Raise i_ready -> o_ready=1 next cycle and a new accept completes.
- Control events:
  - i_flush at T+2 of an equal-operand compare -> o_valid never asserts, o_ready=1 at T+3.
  - i_rst mid-BUSY -> all outputs 0.
  - funct3=010 -> o_illegal=1, o_taken=0, o_valid at T+1.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the multi-cycle branch comparator: funct3 codes,
// FSM state encoding and the taken-decision helper.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  // For legal codes lt/eq/gt are one-hot, so gt|eq reduces to !lt.
  function automatic logic br_taken(input logic [2:0] f3, input logic lt, input logic eq);
    case (f3)
      BR_BEQ:           return eq;
      BR_BNE:           return !eq;
      BR_BLT, BR_BLTU:  return lt;
      BR_BGE, BR_BGEU:  return !lt;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare; flipping the top bit of both
// operands turns an unsigned compare into a two's-complement one.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             is_signed,
  output logic             lt,
  output logic             eq
);

  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    a_x = a;
    b_x = b;
    a_x[CHUNK-1] = a[CHUNK-1] ^ is_signed;
    b_x[CHUNK-1] = b[CHUNK-1] ^ is_signed;
  end

  assign lt = a_x < b_x;
  assign eq = a == b;

endmodule

// File: rtl/branch_cmp_unit.sv
// Multi-cycle branch comparator: walks the operands CHUNK bits per cycle,
// MSB chunk first, and reports taken plus lt/eq/gt for the branch funct3.
module branch_cmp_unit
  import branch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [2:0]       i_funct3,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_illegal,
  output state_t           o_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. o_ready depends on state only; o_valid holds until i_ready.
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       f3_q;
  logic             sgn_q, ill_q, lt_q, gt_q;
  logic [KW-1:0]    k_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             c_lt, c_eq, c_sgn;
  logic             accept;

  assign chunk_a = a_q[k_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[k_q*CHUNK +: CHUNK];
  assign c_sgn   = sgn_q && (k_q == K_TOP);
  assign accept  = (state_q == ST_IDLE) && i_valid && !i_flush;

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a         (chunk_a),
    .b         (chunk_b),
    .is_signed (c_sgn),
    .lt        (c_lt),
    .eq        (c_eq)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_valid) state_d = f3_illegal(i_funct3) ? ST_DONE : ST_BUSY;
      ST_BUSY: if ((EARLY_EXIT && !c_eq) || (k_q == '0)) state_d = ST_DONE;
      ST_DONE: if (i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      sgn_q <= 1'b0;
      ill_q <= 1'b0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
      k_q   <= '0;
    end else if (accept) begin
      a_q   <= i_op_a;
      b_q   <= i_op_b;
      f3_q  <= i_funct3;
      sgn_q <= f3_signed(i_funct3);
      ill_q <= f3_illegal(i_funct3);
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
      k_q   <= K_TOP;
    end else if ((state_q == ST_BUSY) && !i_flush) begin
      // Only the most significant difference decides the result.
      if (!c_eq && !lt_q && !gt_q) begin
        lt_q <= c_lt;
        gt_q <= !c_lt;
      end
      if (k_q != '0) k_q <= k_q - 1'b1;
    end
  end

  always_comb begin
    o_ready   = (state_q == ST_IDLE) && !i_rst;
    o_valid   = (state_q == ST_DONE);
    o_illegal = o_valid && ill_q;
    o_lt      = o_valid && !ill_q && lt_q;
    o_gt      = o_valid && !ill_q && gt_q;
    o_eq      = o_valid && !ill_q && !lt_q && !gt_q;
    o_taken   = o_valid && !ill_q && br_taken(f3_q, lt_q, !lt_q && !gt_q);
    o_state   = state_q;
  end

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed bench for branch_cmp_unit: early-exit and full-scan instances share
// stimulus; a vector table plus hand-written handshake/flush/reset sequences.
module tb_branch_cmp_unit;
  import branch_pkg::*;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst, flush, valid, ready;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [2:0]        funct3;

  logic   rdy0, vld0, tk0, lt0, eq0, gt0, il0;
  logic   rdy1, vld1, tk1, lt1, eq1, gt1, il1;
  state_t st0, st1;
  logic [4:0] fl0, fl1;

  assign fl0 = {tk0, lt0, eq0, gt0, il0};
  assign fl1 = {tk1, lt1, eq1, gt1, il1};

  always #5 clk = ~clk;

  branch_cmp_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy0),
    .i_op_a(op_a), .i_op_b(op_b), .i_funct3(funct3), .o_valid(vld0), .i_ready(ready),
    .o_taken(tk0), .o_lt(lt0), .o_eq(eq0), .o_gt(gt0), .o_illegal(il0), .o_state(st0)
  );

  branch_cmp_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b0)) dut_ne (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy1),
    .i_op_a(op_a), .i_op_b(op_b), .i_funct3(funct3), .o_valid(vld1), .i_ready(ready),
    .o_taken(tk1), .o_lt(lt1), .o_eq(eq1), .o_gt(gt1), .o_illegal(il1), .o_state(st1)
  );

  // Flags are {taken, lt, eq, gt, illegal}; lat is the early-exit latency.
  typedef struct {
    logic [2:0]       f3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       flags;
    int               lat;
    string            name;
  } vec_t;

  vec_t       tbl[14];
  logic [4:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; flush = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst ready low ee1", 32'(rdy0), 32'd0);
    check("rst ready low ee0", 32'(rdy1), 32'd0);
    check("rst outputs ee1", {26'd0, vld0, fl0}, 32'd0);
    check("rst outputs ee0", {26'd0, vld1, fl1}, 32'd0);
    check("rst state", 32'(st0), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("ready after rst ee1", 32'(rdy0), 32'd1);
    check("ready after rst ee0", 32'(rdy1), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int         lat0, lat1;
    logic [4:0] f0, f1, e;
    lat0 = 0; lat1 = 0; f0 = '0; f1 = '0;
    @(negedge clk);
    check({v.name, " ready"}, 32'({rdy0, rdy1}), 32'b11);
    valid = 1'b1; op_a = v.a; op_b = v.b; funct3 = v.f3; ready = 1'b1;
    exp_q.push_back(v.flags);
    @(negedge clk);
    valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (lat0 == 0 && vld0) begin lat0 = c; f0 = fl0; end
      if (lat1 == 0 && vld1) begin lat1 = c; f1 = fl1; end
      if (lat0 != 0 && lat1 != 0) break;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({v.name, " flags ee1"}, 32'(f0), 32'(e));
    check({v.name, " lat ee1"}, 32'(lat0), 32'(v.lat));
    check({v.name, " flags ee0"}, 32'(f1), 32'(e));
    check({v.name, " lat ee0"}, 32'(lat1), v.flags[0] ? 32'd1 : 32'(N + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    logic       seen;
    logic [4:0] held;

    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0;
    op_a = '0; op_b = '0; funct3 = '0;

    tbl[0]  = '{BR_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'b11000, 2, "blt_neg1_vs_1"};
    tbl[1]  = '{BR_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00010, 2, "bltu_max_vs_1"};
    tbl[2]  = '{BR_BEQ,  32'h1234_5678, 32'h1234_5678, 5'b10100, 5, "beq_equal"};
    tbl[3]  = '{BR_BGE,  32'h8000_0000, 32'h0000_0000, 5'b01000, 2, "bge_min_vs_0"};
    tbl[4]  = '{BR_BGE,  32'h0000_0100, 32'h0000_00FF, 5'b10010, 4, "bge_diff_m2"};
    tbl[5]  = '{BR_BNE,  32'h0000_0005, 32'h0000_0005, 5'b00100, 5, "bne_equal"};
    tbl[6]  = '{BR_BGEU, 32'h0000_0010, 32'h0000_0020, 5'b01000, 5, "bgeu_diff_m3"};
    tbl[7]  = '{3'b010,  32'h0000_0001, 32'h0000_0002, 5'b00001, 1, "illegal_010"};
    tbl[8]  = '{3'b011,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1, "illegal_011"};
    tbl[9]  = '{BR_BLT,  32'h7FFF_FFFF, 32'h8000_0000, 5'b00010, 2, "blt_max_vs_min"};
    tbl[10] = '{BR_BNE,  32'h0000_0001, 32'h0000_0000, 5'b10010, 5, "bne_lsb"};
    tbl[11] = '{BR_BGEU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10100, 5, "bgeu_equal"};
    tbl[12] = '{BR_BLTU, 32'h0001_0000, 32'h0002_0000, 5'b11000, 3, "bltu_diff_m1"};
    tbl[13] = '{BR_BLTU, 32'h0001_FFFF, 32'h0002_0000, 5'b11000, 3, "bltu_first_diff_wins"};

    do_reset();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Backpressure: result held while i_ready is low, then back-to-back accept.
    @(negedge clk);
    valid = 1'b1; op_a = 32'h1234_5678; op_b = 32'h1234_5678; funct3 = BR_BEQ; ready = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    c = 1;
    while (!vld0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("bp latency", 32'(c), 32'd5);
    held = fl0;
    check("bp flags", 32'(held), 32'b10100);
    repeat (3) begin
      @(negedge clk);
      check("bp hold valid", 32'({vld0, vld1}), 32'b11);
      check("bp hold flags", 32'(fl0), 32'(held));
      check("bp ready low", 32'({rdy0, rdy1}), 32'b00);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp ready after release", 32'({rdy0, rdy1}), 32'b11);
    check("bp valid dropped", 32'({vld0, vld1}), 32'b00);
    valid = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; funct3 = BR_BLT;
    @(negedge clk);
    valid = 1'b0;
    check("bp next busy", 32'(vld0), 32'd0);
    @(negedge clk);
    check("bp next valid T+2", 32'(vld0), 32'd1);
    check("bp next flags", 32'(fl0), 32'b11000);
    repeat (5) @(negedge clk);

    // Flush two cycles into an equal-operand compare.
    valid = 1'b1; op_a = 32'hCAFE_F00D; op_b = 32'hCAFE_F00D; funct3 = BR_BEQ; ready = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    seen = vld0 | vld1;
    @(negedge clk);
    seen |= vld0 | vld1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush ready at T+3", 32'({rdy0, rdy1}), 32'b11);
    repeat (6) begin
      seen |= vld0 | vld1;
      @(negedge clk);
    end
    check("flush no valid", 32'(seen), 32'd0);

    // Flush coincident with an accept drops the request.
    valid = 1'b1; flush = 1'b1; funct3 = BR_BNE; op_a = 32'h1; op_b = 32'h2;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    check("flush accept stays idle", 32'({rdy0, rdy1}), 32'b11);
    seen = 1'b0;
    repeat (6) begin
      seen |= vld0 | vld1;
      @(negedge clk);
    end
    check("flush accept no valid", 32'(seen), 32'd0);

    // Reset in the middle of BUSY.
    valid = 1'b1; op_a = 32'h5555_AAAA; op_b = 32'h5555_AAAA; funct3 = BR_BEQ;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst outputs ee1", {25'd0, rdy0, vld0, fl0}, 32'd0);
    check("midrst outputs ee0", {25'd0, rdy1, vld1, fl1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready after", 32'({rdy0, rdy1}), 32'b11);
    seen = 1'b0;
    repeat (6) begin
      seen |= vld0 | vld1;
      @(negedge clk);
    end
    check("midrst no valid", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
